// File: rtl/fetch_buffer_if.sv
`default_nettype none
// =============================================================================
// fetch_buffer_if : fetch-unit bus bundle (back-end control, imem, issue side)
// Revision 1.0
// =============================================================================
interface fetch_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int INST_WIDTH = 4,
  parameter int ISSUE      = 2,
  parameter int ADDR_WIDTH = 7
);
  localparam int LANES    = DATA_WIDTH / INST_WIDTH;
  localparam int PC_WIDTH = ADDR_WIDTH + $clog2(LANES);

  logic                        stall;
  logic                        redirect;
  logic [ADDR_WIDTH-1:0]       redirectAddr;
  logic [ADDR_WIDTH-1:0]       addrInst;
  logic                        memReq;
  logic [DATA_WIDTH-1:0]       instIn;
  logic [ISSUE*INST_WIDTH-1:0] instOut;
  logic                        instValid;
  logic [PC_WIDTH-1:0]         pcOut;

  modport master (
    input  stall, redirect, redirectAddr, instIn,
    output addrInst, memReq, instOut, instValid, pcOut
  );

  modport slave (
    output stall, redirect, redirectAddr, instIn,
    input  addrInst, memReq, instOut, instValid, pcOut
  );
endinterface
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// =============================================================================
// fetch_buffer : buffered instruction fetch, DEPTH-word prefetch FIFO, unpacks
//                memory words into ISSUE-wide bundles.  Revision 1.0
// =============================================================================
module fetch_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int INST_WIDTH = 4,
  parameter int ISSUE      = 2,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 4
) (
  input  logic           clk,
  input  logic           reset,
  fetch_buffer_if.master bus
);
  localparam int LANES  = DATA_WIDTH / INST_WIDTH;
  localparam int GROUPS = LANES / ISSUE;
  localparam int BW     = ISSUE * INST_WIDTH;
  localparam int LW     = $clog2(LANES);
  localparam int PCW    = ADDR_WIDTH + LW;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;

  logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr [DEPTH];

  logic [ADDR_WIDTH-1:0] fetch_ptr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  in_flight;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [GW-1:0]         grp;
  logic [BW-1:0]         out_q;
  logic [PCW-1:0]        pc_q;
  logic                  valid_q;

  logic                  req;
  logic                  push;
  logic                  load;
  logic                  bypass;
  logic                  avail;
  logic                  last_grp;
  logic                  pop;
  logic                  fifo_pop;
  logic                  fifo_write;
  logic [DATA_WIDTH-1:0] head_word;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [PCW-1:0]        pc_next;

  always_comb begin
    req       = !reset && !bus.redirect &&
                (({1'b0, count} + {{CW{1'b0}}, in_flight}) < (CW+1)'(DEPTH));
    push      = in_flight && !bus.redirect;
    load      = !bus.stall && !bus.redirect;
    // An empty FIFO forwards the returning word straight to the output register.
    bypass    = (count == '0) && push;
    avail     = (count != '0) || push;
    head_word = bypass ? bus.instIn : fifo_data[rd_ptr];
    head_addr = bypass ? req_addr   : fifo_addr[rd_ptr];
    last_grp  = (grp == GW'(GROUPS - 1));
    pop       = load && avail && last_grp;
    fifo_pop  = pop && !bypass;
    fifo_write = push && !(bypass && pop);
    pc_next   = (PCW'(head_addr) << LW) | PCW'(int'(grp) * ISSUE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_ptr <= '0;
      req_addr  <= '0;
      in_flight <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      grp       <= '0;
      out_q     <= '0;
      pc_q      <= '0;
      valid_q   <= 1'b0;
    end else if (bus.redirect) begin
      fetch_ptr <= bus.redirectAddr;
      in_flight <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      grp       <= '0;
      valid_q   <= 1'b0;
    end else begin
      in_flight <= req;
      if (req) begin
        fetch_ptr <= fetch_ptr + 1'b1;
        req_addr  <= fetch_ptr;
      end
      if (fifo_write) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(fifo_write) - CW'(fifo_pop);
      if (load) begin
        valid_q <= avail;
        if (avail) begin
          out_q <= head_word[int'(grp)*BW +: BW];
          pc_q  <= pc_next;
          grp   <= last_grp ? '0 : grp + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && fifo_write) begin
      fifo_data[wr_ptr] <= bus.instIn;
      fifo_addr[wr_ptr] <= req_addr;
    end
  end

  assign bus.memReq    = req;
  assign bus.addrInst  = reset ? '0 : fetch_ptr;
  assign bus.instOut   = out_q;
  assign bus.instValid = valid_q;
  assign bus.pcOut     = pc_q;

endmodule
`default_nettype wire
